// File: rtl/sram_pkg.sv
// Shared types and derivation helpers for the sram_bank slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_pkg;

  // Bank controller state: INIT zeroes storage, READY serves requests.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Metadata carried alongside an accepted request into the response stage.
  typedef struct packed {
    logic vld;  // a request was accepted on the previous edge
    logic err;  // that request was misaligned or out of range
    logic rd;   // that request was a legal read (array output is the payload)
  } rsp_meta_t;

  // Byte-offset bits inside one word.
  function automatic int calc_off(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits for the given depth.
  function automatic int calc_idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_array.sv
// Raw single-port storage with byte-masked write and registered read; no reset.
// Latency: read data appears 1 cycle after an enabled read.
// Backpressure: none, one access per cycle whenever en is high.
//
// Ports: clk_i clock | en access enable | we 1=write | be byte enables
//        idx word index | wdat write data | rdat registered read data
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = calc_idx_w(DEPTH)
) (
  input  logic                clk_i,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdat,
  output logic [DATA_W-1:0]   rdat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Writes update only the enabled byte lanes; reads leave rdat untouched
  // on non-read cycles so the last read word stays available.
  always_ff @(posedge clk_i) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (be[b]) begin
            mem[idx][8*b +: 8] <= wdat[8*b +: 8];
          end
        end
      end else begin
        rdat <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/sram_bank.sv
// Byte-addressed SRAM bank: self-clearing after reset, then one request/cycle.
// Latency: response 1 cycle after accept (2 cycles with SRAM_OUTREG_EN).
// Backpressure: gnt_o low during the clear sequence, otherwise always granted.
//
// Optional feature macro: SRAM_OUTREG_EN adds an output register stage on
// rvalid_o/rdata_o/err_o.
//
// Ports: clk_i clock | rst_ni async active-low reset
//        req_i/we_i/be_i/addr_i/wdata_i request (byte address, byte enables)
//        gnt_o request accepted | rvalid_o/rdata_o/err_o one-cycle response
//        init_done_o storage clear finished
module sram_bank
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                init_done_o
);

  localparam int OFF   = calc_off(DATA_W);
  localparam int IDX_W = calc_idx_w(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  // Mask of the byte-offset bits; empty when words are a single byte.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

  state_e             state_q;
  logic [IDX_W-1:0]   init_cnt_q;
  logic               gnt_q;
  logic               init_done_q;

  logic               addr_err;
  logic               req_acc;

  logic               arr_en;
  logic               arr_we;
  logic [BE_W-1:0]    arr_be;
  logic [IDX_W-1:0]   arr_idx;
  logic [DATA_W-1:0]  arr_wdat;
  logic [DATA_W-1:0]  arr_rdat;

  rsp_meta_t          rsp_q;
  logic [DATA_W-1:0]  rsp_dat;

  // Anything above the word index or inside the byte offset is an error.
  assign addr_err = ((addr_i >> (OFF + IDX_W)) != '0) || ((addr_i & OFF_MASK) != '0);
  assign req_acc  = req_i && gnt_q;

  // The clear sequence owns the array port in INIT; afterwards only legal
  // accepted requests reach storage.
  always_comb begin
    arr_en   = 1'b0;
    arr_we   = 1'b0;
    arr_be   = '0;
    arr_idx  = addr_i[OFF +: IDX_W];
    arr_wdat = wdata_i;
    if (state_q == INIT) begin
      arr_en   = 1'b1;
      arr_we   = 1'b1;
      arr_be   = '1;
      arr_idx  = init_cnt_q;
      arr_wdat = '0;
    end else if (req_acc && !addr_err) begin
      arr_en   = 1'b1;
      arr_we   = we_i;
      arr_be   = be_i;
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .idx   (arr_idx),
    .wdat  (arr_wdat),
    .rdat  (arr_rdat)
  );

  // Controller FSM. gnt/init_done are registered and flip together with the
  // last clear write, so the first grant lands exactly DEPTH cycles after
  // reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      gnt_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q     <= READY;
            gnt_q       <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  // Response stage aligned with the array's registered read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q.vld <= req_acc;
      rsp_q.err <= req_acc && addr_err;
      rsp_q.rd  <= req_acc && !addr_err && !we_i;
    end
  end

  // Writes and errors answer with zero data.
  assign rsp_dat = rsp_q.rd ? arr_rdat : '0;

`ifdef SRAM_OUTREG_EN
  logic              out_vld_q;
  logic              out_err_q;
  logic [DATA_W-1:0] out_dat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q <= 1'b0;
      out_err_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= rsp_q.vld;
      out_err_q <= rsp_q.vld && rsp_q.err;
      if (rsp_q.vld) begin
        out_dat_q <= rsp_dat;
      end
    end
  end

  assign rvalid_o = out_vld_q;
  assign err_o    = out_err_q;
  assign rdata_o  = out_dat_q;
`else
  // Keeps rdata_o stable between responses; the array output alone would
  // not be zero for write responses or survive later reads.
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (rsp_q.vld) begin
      hold_q <= rsp_dat;
    end
  end

  assign rvalid_o = rsp_q.vld;
  assign err_o    = rsp_q.err;
  assign rdata_o  = rsp_q.vld ? rsp_dat : hold_q;
`endif

  assign gnt_o       = gnt_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank: directed scenarios plus random traffic
// checked every cycle against a word-array/response-queue model.
// Response latency follows SRAM_OUTREG_EN (1 without, 2 with).
module tb_sram_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b1;
  logic        req_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic [3:0]  be_i    = '0;
  logic [31:0] addr_i  = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        init_done_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .init_done_o (init_done_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory is a plain word array; every accepted request queues the response
  // it must produce, tagged with the edge number at which it becomes visible.
  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        m_q[$];
  logic [31:0] m_mem [DEPTH];
  int          m_since = 0;   // rising edges seen out of reset
  int          ecnt    = 0;   // rising edge counter
  logic        m_bad;
  int          m_w;
  rsp_t        m_r;
  logic [31:0] m_last  = '0;  // last response data (owned by compare process)

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_since = 0;
      m_q.delete();
    end else begin
      ecnt++;
      while (m_q.size() > 0 && m_q[0].due < ecnt) m_q.delete(0);
      if (m_since < DEPTH) begin
        m_mem[m_since] = '0;
        m_since++;
      end else if (req_i) begin
        m_bad = (addr_i % 4 != 0) || (addr_i >= 32'(DEPTH * 4));
        m_w   = int'((addr_i / 4) % DEPTH);
        if (!m_bad && we_i) begin
          for (int b = 0; b < 4; b++) begin
            if (be_i[b]) m_mem[m_w][8*b +: 8] = wdata_i[8*b +: 8];
          end
        end
        m_r.due  = ecnt + LAT - 1;
        m_r.err  = m_bad;
        m_r.data = (!m_bad && !we_i) ? m_mem[m_w] : 32'h0;
        m_q.push_back(m_r);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk_i) begin
    #2;
    if (!rst_ni) m_last = '0;
    chk1("gnt", gnt_o, rst_ni && (m_since >= DEPTH));
    chk1("init_done", init_done_o, rst_ni && (m_since >= DEPTH));
    if (m_q.size() > 0 && m_q[0].due == ecnt) begin
      chk1("rvalid", rvalid_o, 1'b1);
      chk1("err", err_o, m_q[0].err);
      chk("rdata", rdata_o, m_q[0].data);
      m_last = m_q[0].data;
    end else begin
      chk1("rvalid idle", rvalid_o, 1'b0);
      chk1("err idle", err_o, 1'b0);
      chk("rdata hold", rdata_o, m_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk_i);
    req_i   = 1'b1;
    we_i    = we;
    be_i    = be;
    addr_i  = a;
    wdata_i = d;
  endtask

  task automatic idle();
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  // Issue one request, then check the response exactly LAT cycles later.
  task automatic issue_chk(input string name, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_dat);
    drive(we, be, a, d);
    @(posedge clk_i);
    #3;
    req_i = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk_i);
      #3;
    end
    chk1({name, " rvalid"}, rvalid_o, 1'b1);
    chk1({name, " err"}, err_o, exp_err);
    chk({name, " rdata"}, rdata_o, exp_dat);
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned sel;
    logic [31:0] base;
    sel  = $urandom_range(0, 9);
    base = 32'($urandom_range(0, 15)) * 32'd4;
    if (sel == 8) return base | 32'($urandom_range(1, 3));
    if (sel == 9) return base | (($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h8000_0000);
    return base;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int w;
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // Clear phase with writes hammering words 0..15: all must be ignored.
    for (int k = 1; k <= DEPTH; k++) begin
      req_i   = 1'b1;
      we_i    = 1'b1;
      be_i    = 4'hF;
      addr_i  = 32'($urandom_range(0, 15)) * 32'd4;
      wdata_i = $urandom();
      @(posedge clk_i);
      #3;
      if (k == DEPTH - 1) begin
        chk1("gnt before last clear", gnt_o, 1'b0);
        chk1("init_done before last clear", init_done_o, 1'b0);
      end
    end
    req_i = 1'b0;
    chk1("gnt at cycle DEPTH", gnt_o, 1'b1);
    chk1("init_done at cycle DEPTH", init_done_o, 1'b1);
    issue_chk("read 0xFFC", 1'b0, 4'hF, 32'h0FFC, 32'h0, 1'b0, 32'h0);

    // Partial-byte write merge and read right after write.
    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    drive(1'b1, 4'h3, 32'h10, 32'h00001122);
    issue_chk("merged read", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEAD1122);

    // Address errors never touch storage.
    issue_chk("misaligned read", 1'b0, 4'hF, 32'h1002, 32'h0, 1'b1, 32'h0);
    issue_chk("oor read", 1'b0, 4'hF, 32'h1000, 32'h0, 1'b1, 32'h0);
    issue_chk("oor write", 1'b1, 4'hF, 32'h1010, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue_chk("misaligned write", 1'b1, 4'hF, 32'h0012, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue_chk("word 0 intact", 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0);
    issue_chk("word 0x10 intact", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEAD1122);
    issue_chk("be=0 write", 1'b1, 4'h0, 32'h10, 32'h12345678, 1'b0, 32'h0);
    issue_chk("after be=0", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEAD1122);

    // Back-to-back reads: eight pulses in order with no gaps.
    for (int i = 0; i < 8; i++) drive(1'b1, 4'hF, 32'(i * 4), 32'hC0DE0000 + 32'(i));
    fork
      begin
        for (int i = 0; i < 8; i++) drive(1'b0, 4'hF, 32'(i * 4), 32'h0);
        idle();
      end
      begin
        @(negedge clk_i);
        @(posedge clk_i);
        #3;
        for (int j = 1; j < LAT; j++) begin
          @(posedge clk_i);
          #3;
        end
        for (int i = 0; i < 8; i++) begin
          chk1("b2b rvalid", rvalid_o, 1'b1);
          chk("b2b rdata", rdata_o, 32'hC0DE0000 + 32'(i));
          @(posedge clk_i);
          #3;
        end
        chk1("b2b train ends", rvalid_o, 1'b0);
      end
    join

    // Random traffic, checked by the per-cycle compare.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) < 7)
        drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rnd_addr(), $urandom());
      else
        idle();
    end
    idle();

    // Reset pulse while a read is in flight.
    drive(1'b1, 4'hF, 32'h10, 32'hA5A5A5A5);
    drive(1'b0, 4'hF, 32'h10, 32'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #2;
    req_i = 1'b0;
    chk1("rvalid dropped by reset", rvalid_o, 1'b0);
    chk1("gnt dropped by reset", gnt_o, 1'b0);
    chk("rdata cleared by reset", rdata_o, 32'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    w = 0;
    while (!gnt_o && w < 2 * DEPTH) begin
      @(posedge clk_i);
      #3;
      w++;
    end
    chk("clear restart cycles", 32'(w), 32'(DEPTH));
    issue_chk("0x10 after reset", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h0);

    idle();
    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
